// File: rtl/tank_sprite_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tank_sprite_scheduler
// Description : Per-pixel tank sprite arbiter that shares one set of sprite
//               ROMs, with a double-buffered tank table and overlap counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tank_sprite_scheduler #(
    parameter int NUM_TANKS   = 4,
    parameter int SPRITE_SIZE = 32,
    localparam int c_slot_w   = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1,
    localparam int c_addr_w   = $clog2(SPRITE_SIZE * SPRITE_SIZE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                wr_en,
    input  logic [c_slot_w-1:0] wr_slot,
    input  logic [9:0]          wr_x,
    input  logic [9:0]          wr_y,
    input  logic [1:0]          wr_dir,
    input  logic                wr_enemy,
    input  logic                wr_active,
    input  logic                pix_valid,
    input  logic [9:0]          draw_x,
    input  logic [9:0]          draw_y,
    output logic [c_addr_w-1:0] rom_address,
    output logic [1:0]          dir_sel,
    output logic                enemy,
    output logic                hit,
    output logic [15:0]         overlap_count
);

    localparam int          c_sz_w     = $clog2(SPRITE_SIZE);
    localparam logic [10:0] c_size_ext = 11'(SPRITE_SIZE);
    localparam logic [15:0] c_cnt_max  = 16'hFFFF;

    // Shadow (game-logic side) and committed (render side) tank tables
    logic [9:0] r_sh_x      [NUM_TANKS];
    logic [9:0] r_sh_y      [NUM_TANKS];
    logic [1:0] r_sh_dir    [NUM_TANKS];
    logic       r_sh_enemy  [NUM_TANKS];
    logic       r_sh_active [NUM_TANKS];
    logic [9:0] r_cm_x      [NUM_TANKS];
    logic [9:0] r_cm_y      [NUM_TANKS];
    logic [1:0] r_cm_dir    [NUM_TANKS];
    logic       r_cm_enemy  [NUM_TANKS];
    logic       r_cm_active [NUM_TANKS];

    logic [NUM_TANKS-1:0] w_hit;
    logic [c_sz_w-1:0]    w_dx [NUM_TANKS];
    logic [c_sz_w-1:0]    w_dy [NUM_TANKS];
    logic                 w_multi;
    logic                 w_win_found;
    logic [c_addr_w-1:0]  w_win_addr;
    logic [1:0]           w_win_dir;
    logic                 w_win_enemy;

    logic [c_addr_w-1:0]  r_rom_address;
    logic                 r_s1_hit;
    logic [1:0]           r_s1_dir;
    logic                 r_s1_enemy;
    logic                 r_hit;
    logic [1:0]           r_dir_sel;
    logic                 r_enemy;
    logic [15:0]          r_run_count;
    logic [15:0]          r_overlap_count;

    // Commit reads the shadow's pre-edge value, so a coincident write lands next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TANKS; i++) begin
                r_sh_x[i]      <= '0;
                r_sh_y[i]      <= '0;
                r_sh_dir[i]    <= '0;
                r_sh_enemy[i]  <= 1'b0;
                r_sh_active[i] <= 1'b0;
                r_cm_x[i]      <= '0;
                r_cm_y[i]      <= '0;
                r_cm_dir[i]    <= '0;
                r_cm_enemy[i]  <= 1'b0;
                r_cm_active[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_TANKS; i++) begin
                if (frame_start) begin
                    r_cm_x[i]      <= r_sh_x[i];
                    r_cm_y[i]      <= r_sh_y[i];
                    r_cm_dir[i]    <= r_sh_dir[i];
                    r_cm_enemy[i]  <= r_sh_enemy[i];
                    r_cm_active[i] <= r_sh_active[i];
                end
                if (wr_en && (wr_slot == c_slot_w'(i))) begin
                    r_sh_x[i]      <= wr_x;
                    r_sh_y[i]      <= wr_y;
                    r_sh_dir[i]    <= wr_dir;
                    r_sh_enemy[i]  <= wr_enemy;
                    r_sh_active[i] <= wr_active;
                end
            end
        end
    end

    // 11-bit bounds so a sprite hanging off the right/bottom edge never wraps to 0
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_TANKS; i++) begin
            w_dx[i]  = draw_x[c_sz_w-1:0] - r_cm_x[i][c_sz_w-1:0];
            w_dy[i]  = draw_y[c_sz_w-1:0] - r_cm_y[i][c_sz_w-1:0];
            w_hit[i] = r_cm_active[i] && pix_valid
                    && ({1'b0, draw_x} >= {1'b0, r_cm_x[i]})
                    && ({1'b0, draw_x} <  ({1'b0, r_cm_x[i]} + c_size_ext))
                    && ({1'b0, draw_y} >= {1'b0, r_cm_y[i]})
                    && ({1'b0, draw_y} <  ({1'b0, r_cm_y[i]} + c_size_ext));
        end
    end

    // Descending scan: the last assignment, i.e. the lowest hitting index, wins
    always_comb begin
        w_win_found = 1'b0;
        w_win_addr  = '0;
        w_win_dir   = '0;
        w_win_enemy = 1'b0;
        for (int i = NUM_TANKS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_win_found = 1'b1;
                w_win_addr  = {w_dy[i], w_dx[i]};
                w_win_dir   = r_cm_dir[i];
                w_win_enemy = r_cm_enemy[i];
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more slots hit
    assign w_multi = |(w_hit & (w_hit - NUM_TANKS'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rom_address <= '0;
            r_s1_hit      <= 1'b0;
            r_s1_dir      <= '0;
            r_s1_enemy    <= 1'b0;
            r_hit         <= 1'b0;
            r_dir_sel     <= '0;
            r_enemy       <= 1'b0;
        end else begin
            r_rom_address <= w_win_addr;
            r_s1_hit      <= w_win_found;
            r_s1_dir      <= w_win_dir;
            r_s1_enemy    <= w_win_enemy;
            r_hit         <= r_s1_hit;
            r_dir_sel     <= r_s1_dir;
            r_enemy       <= r_s1_enemy;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_count     <= '0;
            r_overlap_count <= '0;
        end else if (frame_start) begin
            r_overlap_count <= r_run_count;
            r_run_count     <= w_multi ? 16'd1 : 16'd0;
        end else if (w_multi && (r_run_count != c_cnt_max)) begin
            r_run_count <= r_run_count + 16'd1;
        end
    end

    assign rom_address   = r_rom_address;
    assign dir_sel       = r_dir_sel;
    assign enemy         = r_enemy;
    assign hit           = r_hit;
    assign overlap_count = r_overlap_count;

endmodule
`default_nettype wire

// File: tb/tb_tank_sprite_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tank_sprite_scheduler
// Description : Directed and randomized bench against a table-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tank_sprite_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_slot = '0;
    logic [9:0] wr_x = '0;
    logic [9:0] wr_y = '0;
    logic [1:0] wr_dir = '0;
    logic       wr_enemy = 1'b0;
    logic       wr_active = 1'b0;
    logic       pix_valid = 1'b0;
    logic [9:0] draw_x = '0;
    logic [9:0] draw_y = '0;
    logic [9:0] rom_address;
    logic [1:0] dir_sel;
    logic       enemy;
    logic       hit;
    logic [15:0] overlap_count;

    int tests = 0;
    int failed = 0;

    typedef struct { int x; int y; int dir; int enemy; int active; } slot_t;
    typedef struct { int addr; int hit; int dir; int enemy; } res_t;

    slot_t sh [4];
    slot_t cm [4];
    res_t  s1, s2;
    int    run_cnt, ov_cnt;

    tank_sprite_scheduler dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .wr_en(wr_en),
        .wr_slot(wr_slot), .wr_x(wr_x), .wr_y(wr_y), .wr_dir(wr_dir),
        .wr_enemy(wr_enemy), .wr_active(wr_active), .pix_valid(pix_valid),
        .draw_x(draw_x), .draw_y(draw_y), .rom_address(rom_address),
        .dir_sel(dir_sel), .enemy(enemy), .hit(hit), .overlap_count(overlap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Geometric reference: scan slots in priority order over the committed table
    function automatic res_t eval(output int n);
        res_t r;
        int px, py;
        r = '{0, 0, 0, 0};
        n = 0;
        px = int'(draw_x);
        py = int'(draw_y);
        for (int i = 0; i < 4; i++) begin
            if (pix_valid && cm[i].active != 0 &&
                px >= cm[i].x && px < cm[i].x + 32 &&
                py >= cm[i].y && py < cm[i].y + 32) begin
                n++;
                if (r.hit == 0)
                    r = '{(py - cm[i].y) * 32 + (px - cm[i].x), 1, cm[i].dir, cm[i].enemy};
            end
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            sh[i] = '{0, 0, 0, 0, 0};
            cm[i] = '{0, 0, 0, 0, 0};
        end
        s1 = '{0, 0, 0, 0};
        s2 = '{0, 0, 0, 0};
        run_cnt = 0;
        ov_cnt = 0;
    endtask

    // One pixel clock: evaluate current inputs, advance model at the edge, check at negedge
    task automatic cycle();
        res_t r;
        int n;
        r = eval(n);
        @(posedge clk);
        s2 = s1;
        s1 = r;
        if (frame_start) begin
            ov_cnt = run_cnt;
            run_cnt = (n >= 2) ? 1 : 0;
        end else if (n >= 2 && run_cnt < 65535) begin
            run_cnt++;
        end
        if (frame_start) cm = sh;
        if (wr_en) sh[wr_slot] = '{int'(wr_x), int'(wr_y), int'(wr_dir), int'(wr_enemy), int'(wr_active)};
        @(negedge clk);
        chk("rom_address", int'(rom_address), s1.addr);
        chk("hit", int'(hit), s2.hit);
        chk("dir_sel", int'(dir_sel), s2.dir);
        chk("enemy", int'(enemy), s2.enemy);
        chk("overlap_count", int'(overlap_count), ov_cnt);
    endtask

    task automatic set_wr(input int slot, input int x, input int y, input int dir,
                          input int en, input int act);
        wr_en = 1'b1;
        wr_slot = 2'(slot);
        wr_x = 10'(x);
        wr_y = 10'(y);
        wr_dir = 2'(dir);
        wr_enemy = 1'(en);
        wr_active = 1'(act);
    endtask

    task automatic pix(input int v, input int x, input int y);
        pix_valid = 1'(v);
        draw_x = 10'(x);
        draw_y = 10'(y);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_addr"}, int'(rom_address), 0);
        chk({tag, "_hit"}, int'(hit), 0);
        chk({tag, "_dir"}, int'(dir_sel), 0);
        chk({tag, "_enemy"}, int'(enemy), 0);
        chk({tag, "_ovl"}, int'(overlap_count), 0);
    endtask

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b0;

        // 1: traffic and shadow writes, but nothing committed
        for (int k = 0; k < 20; k++) begin
            if (k == 3) set_wr(0, 100, 50, 1, 0, 1);
            else wr_en = 1'b0;
            pix(1, 95 + k, 48 + k);
            cycle();
        end
        wr_en = 1'b0;
        chk("t1_ovl", int'(overlap_count), 0);

        // 2: slot1 enemy tank facing left
        set_wr(0, 0, 0, 0, 0, 0); cycle();
        set_wr(1, 100, 50, 2, 1, 1); cycle();
        wr_en = 1'b0; frame_start = 1'b1; cycle();
        frame_start = 1'b0;
        pix(1, 105, 53); cycle();
        chk("t2_addr", int'(rom_address), 101);
        pix(1, 132, 53); cycle();
        chk("t2_hit", int'(hit), 1);
        chk("t2_dir", int'(dir_sel), 2);
        chk("t2_enemy", int'(enemy), 1);
        pix(0, 0, 0); cycle();
        chk("t2_edge_miss", int'(hit), 0);

        // 3: player slot0 overlaps slot1
        set_wr(0, 100, 50, 3, 0, 1); cycle();
        set_wr(1, 110, 60, 2, 1, 1); cycle();
        wr_en = 1'b0; frame_start = 1'b1; cycle();
        frame_start = 1'b0;
        pix(1, 115, 65); cycle();
        chk("t3_addr", int'(rom_address), 495);
        pix(0, 0, 0); frame_start = 1'b1; cycle();
        frame_start = 1'b0;
        chk("t3_enemy", int'(enemy), 0);
        chk("t3_ovl", int'(overlap_count), 1);

        // 4: mid-frame rewrite is invisible until the commit
        set_wr(1, 300, 50, 2, 1, 1); pix(1, 112, 62); cycle();
        wr_en = 1'b0;
        set_wr(0, 0, 0, 0, 0, 0); pix(1, 120, 70); cycle();
        wr_en = 1'b0; pix(1, 135, 85); cycle();
        chk("t4_old_addr", int'(rom_address), 25 * 32 + 25);
        frame_start = 1'b1; pix(0, 0, 0); cycle();
        frame_start = 1'b0; pix(1, 300, 50); cycle();
        chk("t4_new_addr", int'(rom_address), 0);
        pix(0, 0, 0); cycle();
        chk("t4_new_hit", int'(hit), 1);

        // 5: right-edge sprite and a write coinciding with a commit
        set_wr(2, 1000, 200, 1, 1, 1); cycle();
        wr_en = 1'b0; frame_start = 1'b1; cycle();
        frame_start = 1'b0;
        pix(1, 1010, 210); cycle();
        chk("t5_edge_addr", int'(rom_address), 10 * 32 + 10);
        pix(1, 5, 210); cycle();
        chk("t5_edge_hit", int'(hit), 1);
        pix(0, 0, 0); cycle();
        chk("t5_nowrap", int'(hit), 0);
        set_wr(3, 400, 400, 3, 0, 1); frame_start = 1'b1; cycle();
        wr_en = 1'b0; frame_start = 1'b0;
        pix(1, 405, 405); cycle();
        cycle();
        chk("t5_deferred", int'(hit), 0);
        frame_start = 1'b1; pix(0, 0, 0); cycle();
        frame_start = 1'b0; pix(1, 405, 405); cycle();
        cycle();
        chk("t5_committed", int'(hit), 1);

        // Randomized frames with rewrites, commits and overlaps
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0)
                set_wr(int'($urandom_range(0, 3)), int'($urandom_range(100, 160)),
                       int'($urandom_range(50, 110)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 3) != 0));
            else
                wr_en = 1'b0;
            frame_start = ($urandom_range(0, 29) == 0);
            pix(int'($urandom_range(0, 7) != 0), int'($urandom_range(90, 200)),
                int'($urandom_range(40, 150)));
            cycle();
        end
        wr_en = 1'b0;
        frame_start = 1'b0;

        // 6: asynchronous reset during back-to-back hits
        set_wr(0, 600, 300, 1, 1, 1); cycle();
        wr_en = 1'b0; frame_start = 1'b1; cycle();
        frame_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pix(1, 605 + k, 305); cycle();
        end
        #2 reset = 1'b1;
        #1 chk_zero_outputs("t6_async");
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pix(1, 605 + k, 305); cycle();
        end
        chk("t6_no_hit", int'(hit), 0);
        set_wr(0, 600, 300, 1, 1, 1); cycle();
        wr_en = 1'b0; frame_start = 1'b1; cycle();
        frame_start = 1'b0; pix(1, 610, 310); cycle();
        cycle();
        chk("t6_recommit", int'(hit), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
